// File: rtl/eng_job_sched_pkg.sv
// Shared state encoding and default sizing for the engine job sequencer.
package eng_job_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } sched_st_t;

  localparam int K_MAX_DEF  = 128;
  localparam int K_MIN_DEF  = 2;
  localparam int M_MAX_DEF  = 128;
  localparam int M_MIN_DEF  = 2;
  localparam int KREG_W_DEF = $clog2(K_MAX_DEF);
  localparam int MREG_W_DEF = $clog2(M_MAX_DEF);

endpackage

// File: rtl/eng_job_sched_down_cnt.sv
// Loadable down-counter; zero_nxt_o reports the value the counter takes at the next edge.
module eng_job_sched_down_cnt #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         zero_nxt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement so an abort can clear a counter mid-beat.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o     = (cnt_q == '0);
  assign zero_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/eng_job_sched.sv
// Host-side job sequencer: loads K/M into the engine, meters start_eng beats, waits for drain.
module eng_job_sched
  import eng_job_sched_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEF,
  parameter int K_MIN         = K_MIN_DEF,
  parameter int M_MAX         = M_MAX_DEF,
  parameter int M_MIN         = M_MIN_DEF,
  parameter int PACKET_LENGTH = 2,
  parameter int NPKT_W        = 16,
  parameter int LVL_W         = 8,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int KREG_W        = $clog2(K_MAX),
  parameter int MREG_W        = $clog2(M_MAX),
  parameter int BEAT_W        = NPKT_W + $clog2(PACKET_LENGTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [KREG_W-1:0] job_k,
  input  logic [MREG_W-1:0] job_m,
  input  logic [NPKT_W-1:0] job_npkt,
  input  logic              job_abort,
  input  logic [LVL_W-1:0]  inbuff_level,
  input  logic              eng_empty,
  output logic              start_eng,
  output logic [MREG_W-1:0] MReg,
  output logic [KREG_W-1:0] KReg,
  output logic              busy,
  output logic              job_done,
  output logic              job_err
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT);

  sched_st_t         state_q, state_d;
  logic              start_eng_q, start_eng_d;
  logic [KREG_W-1:0] kreg_q, kreg_d;
  logic [MREG_W-1:0] mreg_q, mreg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              aborted_q, aborted_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic              cnt_load_s;
  logic [BEAT_W-1:0] cnt_val_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic              cnt_zero_nxt_s;
  logic [LVL_W-1:0]  lvl_thr_s;
  logic              run_go_s;
  logic              desc_bad_s;
  logic [BEAT_W-1:0] job_beats_s;

  // While start_eng is high one word is already being consumed, so a level of 1 is not enough.
  assign lvl_thr_s   = start_eng_q ? LVL_W'(1) : LVL_W'(0);
  assign run_go_s    = ~cnt_zero_nxt_s & (inbuff_level > lvl_thr_s);
  assign desc_bad_s  = (job_k < KREG_W'(K_MIN)) | (job_m < MREG_W'(M_MIN)) | (job_npkt == '0);
  assign job_beats_s = BEAT_W'(job_npkt) * BEAT_W'(PACKET_LENGTH);
  assign cnt_dec_s   = (state_q == ST_RUN) & start_eng_q & ~cnt_zero_s;

  eng_job_sched_down_cnt #(.W(BEAT_W)) u_beats (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s),
    .zero_nxt_o (cnt_zero_nxt_s)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    start_eng_d = 1'b0;
    kreg_d      = kreg_q;
    mreg_d      = mreg_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    aborted_d   = aborted_q;
    to_d        = to_q;
    cnt_load_s  = 1'b0;
    cnt_val_s   = '0;
    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        to_d      = '0;
        if (job_valid) begin
          if (desc_bad_s) begin
            err_d = 1'b1;
          end else begin
            kreg_d     = job_k;
            mreg_d     = job_m;
            cnt_load_s = 1'b1;
            cnt_val_s  = job_beats_s;
            state_d    = ST_LOAD0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD0, ST_LOAD1, ST_RUN: begin
        if (job_abort) begin
          cnt_load_s = 1'b1;
          aborted_d  = 1'b1;
          to_d       = '0;
          state_d    = ST_DRAIN;
        end else if (state_q == ST_LOAD0) begin
          state_d = ST_LOAD1;
        end else begin
          start_eng_d = run_go_s;
          to_d        = '0;
          state_d     = (state_q == ST_RUN && cnt_zero_nxt_s) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        to_d = to_q + TO_W'(1);
        // The first DRAIN cycle may still see a stale empty flag, so it is ignored.
        if ((to_q != '0) && eng_empty) begin
          done_d  = ~aborted_q;
          err_d   = aborted_q;
          state_d = ST_DONE;
        end else if (to_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_eng_q <= 1'b0;
      kreg_q      <= '0;
      mreg_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      start_eng_q <= start_eng_d;
      kreg_q      <= kreg_d;
      mreg_q      <= mreg_d;
      done_q      <= done_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
      to_q        <= to_d;
    end
  end

  assign job_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign start_eng = start_eng_q;
  assign KReg      = kreg_q;
  assign MReg      = mreg_q;
  assign job_done  = done_q;
  assign job_err   = err_q;

endmodule

// File: tb/tb_eng_job_sched.sv
// Self-checking bench for eng_job_sched: scenario tasks plus a completion scoreboard.
module tb_eng_job_sched;

  localparam int KW = 7;
  localparam int MW = 7;
  localparam int NW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [KW-1:0] job_k;
  logic [MW-1:0] job_m;
  logic [NW-1:0] job_npkt;
  logic          job_abort;
  logic [LW-1:0] inbuff_level;
  logic          eng_empty;
  logic          start_eng;
  logic [MW-1:0] MReg;
  logic [KW-1:0] KReg;
  logic          busy;
  logic          job_done;
  logic          job_err;

  always #5 clk = ~clk;

  eng_job_sched #(.DRAIN_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_k        (job_k),
    .job_m        (job_m),
    .job_npkt     (job_npkt),
    .job_abort    (job_abort),
    .inbuff_level (inbuff_level),
    .eng_empty    (eng_empty),
    .start_eng    (start_eng),
    .MReg         (MReg),
    .KReg         (KReg),
    .busy         (busy),
    .job_done     (job_done),
    .job_err      (job_err)
  );

  typedef struct {
    logic is_err;
    int   beats;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   errors = 0;
  int   mon_beats = 0;

  // Scoreboard: count engine beats per job and compare each completion against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      mon_beats = 0;
    end else begin
      if (start_eng) mon_beats++;
      if (job_done || job_err) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: done=%0b err=%0b with no job outstanding", job_done, job_err);
        end else begin
          sb_e = sb_q.pop_front();
          if ({job_done, job_err} !== {~sb_e.is_err, sb_e.is_err} || mon_beats != sb_e.beats) begin
            errors++;
            $display("FAIL sb_completion: got done=%0b err=%0b beats=%0d, expected err=%0b beats=%0d",
                     job_done, job_err, mon_beats, sb_e.is_err, sb_e.beats);
          end
        end
        mon_beats = 0;
      end
    end
  end

  task automatic submit(input int k, input int m, input int npkt, input logic exp_err, input int exp_beats);
    exp_t e;
    e.is_err = exp_err;
    e.beats  = exp_beats;
    sb_q.push_back(e);
    job_k     = k[KW-1:0];
    job_m     = m[MW-1:0];
    job_npkt  = npkt[NW-1:0];
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_k     = '0;
    job_m     = '0;
    job_npkt  = '0;
  endtask

  task automatic wait_done(input int budget, output logic got_done, output logic got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (job_done || job_err) begin
        got_done = job_done;
        got_err  = job_err;
        break;
      end
    end
    if (!(got_done || got_err)) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no completion within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({start_eng, MReg, KReg, job_done, job_err, busy, job_ready} !== {1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: start=%0b M=%0d K=%0d done=%0b err=%0b busy=%0b ready=%0b, expected 0 0 0 0 0 0 1",
               start_eng, MReg, KReg, job_done, job_err, busy, job_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   highs;
    logic gd, ge;
    inbuff_level = 8'd8;
    eng_empty    = 1'b0;
    submit(4, 2, 3, 1'b0, 6);
    checks++;
    if (KReg !== 7'd4 || MReg !== 7'd2 || start_eng !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_load0: K=%0d M=%0d start=%0b busy=%0b, expected 4 2 0 1", KReg, MReg, start_eng, busy);
    end
    @(negedge clk);
    checks++;
    if (start_eng !== 1'b0) begin
      errors++;
      $display("FAIL basic_load1: start=%0b expected 0", start_eng);
    end
    @(negedge clk);
    checks++;
    if (start_eng !== 1'b1) begin
      errors++;
      $display("FAIL basic_run_start: start=%0b expected 1", start_eng);
    end
    highs = 0;
    for (int i = 0; i < 40 && start_eng === 1'b1; i++) begin
      highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 6) begin
      errors++;
      $display("FAIL basic_run_len: %0d high cycles, expected 6", highs);
    end
    repeat (3) @(negedge clk);
    eng_empty = 1'b1;
    wait_done(40, gd, ge);
    eng_empty = 1'b0;
    @(negedge clk);
    checks++;
    if (job_done !== 1'b0 || job_ready !== 1'b1 || KReg !== 7'd4 || MReg !== 7'd2) begin
      errors++;
      $display("FAIL basic_after_done: done=%0b ready=%0b K=%0d M=%0d, expected 0 1 4 2", job_done, job_ready, KReg, MReg);
    end
  endtask

  task automatic test_pause;
    int   highs;
    logic gd, ge;
    inbuff_level = 8'd8;
    submit(4, 2, 3, 1'b0, 6);
    repeat (3) @(negedge clk);
    inbuff_level = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (start_eng !== 1'b0) begin
        errors++;
        $display("FAIL pause_low[%0d]: start=%0b expected 0", i, start_eng);
      end
      if (i == 4) inbuff_level = 8'd8;
    end
    @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40 && start_eng === 1'b1; i++) begin
      highs++;
      @(negedge clk);
    end
    checks++;
    if (highs != 4) begin
      errors++;
      $display("FAIL pause_resume_len: %0d high cycles after resume, expected 4", highs);
    end
    repeat (2) @(negedge clk);
    eng_empty = 1'b1;
    wait_done(40, gd, ge);
    eng_empty = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_desc;
    submit(4, 1, 3, 1'b1, 0);
    checks++;
    if (job_err !== 1'b1 || busy !== 1'b0 || start_eng !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_m: err=%0b busy=%0b start=%0b ready=%0b, expected 1 0 0 1", job_err, busy, start_eng, job_ready);
    end
    submit(4, 2, 0, 1'b1, 0);
    checks++;
    if (job_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_npkt: err=%0b busy=%0b, expected 1 0", job_err, busy);
    end
    submit(1, 2, 1, 1'b1, 0);
    checks++;
    if (job_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_k: err=%0b busy=%0b, expected 1 0", job_err, busy);
    end
    @(negedge clk);
    checks++;
    if (job_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_err_pulse: err=%0b busy=%0b, expected 0 0", job_err, busy);
    end
  endtask

  task automatic test_timeout;
    inbuff_level = 8'd8;
    eng_empty    = 1'b0;
    submit(2, 2, 1, 1'b1, 2);
    for (int i = 0; i < 20 && !(busy === 1'b1 && start_eng === 1'b0 && i > 3); i++) @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks++;
        if (job_err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL timeout_early: err=%0b busy=%0b, expected 0 1", job_err, busy);
        end
      end
      if (i == 16) begin
        checks++;
        if (job_err !== 1'b1 || busy !== 1'b0 || job_ready !== 1'b1 || job_done !== 1'b0) begin
          errors++;
          $display("FAIL timeout_err: err=%0b busy=%0b ready=%0b done=%0b, expected 1 0 1 0", job_err, busy, job_ready, job_done);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic gd, ge;
    inbuff_level = 8'd8;
    submit(4, 2, 5, 1'b1, 3);
    repeat (4) @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    checks++;
    if (start_eng !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_stop: start=%0b busy=%0b, expected 0 1", start_eng, busy);
    end
    repeat (2) @(negedge clk);
    eng_empty = 1'b1;
    wait_done(40, gd, ge);
    eng_empty = 1'b0;
    checks++;
    if (gd !== 1'b0 || ge !== 1'b1) begin
      errors++;
      $display("FAIL abort_result: done=%0b err=%0b, expected 0 1", gd, ge);
    end
    @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || job_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ignored: busy=%0b err=%0b, expected 0 0", busy, job_err);
    end
  endtask

  task automatic test_reset_mid_run;
    logic gd, ge;
    inbuff_level = 8'd8;
    submit(4, 2, 5, 1'b0, 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({start_eng, MReg, KReg, job_done, job_err, busy, job_ready} !== {1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrun_reset: start=%0b M=%0d K=%0d done=%0b err=%0b busy=%0b ready=%0b, expected 0 0 0 0 0 0 1",
               start_eng, MReg, KReg, job_done, job_err, busy, job_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    submit(3, 3, 1, 1'b0, 2);
    checks++;
    if (KReg !== 7'd3 || MReg !== 7'd3) begin
      errors++;
      $display("FAIL after_reset_load: K=%0d M=%0d, expected 3 3", KReg, MReg);
    end
    repeat (5) @(negedge clk);
    eng_empty = 1'b1;
    wait_done(40, gd, ge);
    eng_empty = 1'b0;
    checks++;
    if (gd !== 1'b1 || ge !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_done: done=%0b err=%0b, expected 1 0", gd, ge);
    end
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    job_valid    = 1'b0;
    job_k        = '0;
    job_m        = '0;
    job_npkt     = '0;
    job_abort    = 1'b0;
    inbuff_level = '0;
    eng_empty    = 1'b0;
    test_reset;
    test_basic;
    test_pause;
    test_bad_desc;
    test_timeout;
    test_abort;
    test_reset_mid_run;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d jobs never completed, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
